alex_relay_sequencer: RTL and testbench
=======================================

# alex_relay_sequencer

Sequences Alex filter-board relay updates for the LPF/HPF band decoders. It watches the 7-bit LPF code, the 6-bit HPF code and the PTT request. On any change it serially shifts a 16-bit relay word to the Alex shift registers, pulses the load strobe, then waits a relay settle time. It also interlocks the transmitter so RF is never granted while relays are switching.

## Interface
- `DIV`, 4: clock cycles per SPI_clock half-period; legal range 1–255.
- `SETTLE`, 2048: clock cycles of relay settle time after the strobe; legal range 1–65535.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `LPF`  in  7  one-hot LPF code from the LPF band decoder.
- `HPF`  in  6  one-hot HPF code from the HPF band decoder.
- `ptt_req`  in  1  transmit request from the host/PTT logic.
- `tx_grant`  out  1  transmitter may radiate; registered.
- `SPI_data`  out  1  serial relay data, MSB first.
- `SPI_clock`  out  1  serial clock to the Alex shift registers.
- `Tx_load_strobe`  out  1  latch pulse to the Alex output registers.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Relay word layout, `word[15:0]`:
  - `[15]` = TX relay (`ptt_req`).
  - `[14:8]` = `LPF`.
  - `[7:2]` = `HPF`.
  - `[1:0]` = 2'b00.
- Internal registers: `sent_word[15:0]` and `sent_valid`. Reset clears `sent_valid`, so the first word after reset is always sent.
- FSM states and transitions:
  - IDLE: if `!sent_valid` or the live word ≠ `sent_word`, go to LOAD.
  - LOAD: one cycle. Capture the live word into `shift_reg` and `sent_word`, set `sent_valid`, clear the bit counter. Go to SHIFT.
  - SHIFT: 16 bits, MSB first.
    - Each bit: `SPI_data` = `shift_reg[15]`; `SPI_clock` low for DIV cycles, then high for DIV cycles.
    - On the falling edge (end of the high phase), shift left by one and increment the 4-bit counter.
    - After the 16th high phase, go to STROBE.
  - STROBE: `Tx_load_strobe` high for DIV cycles; `SPI_clock` and `SPI_data` low. Go to SETTLE.
  - SETTLE: 16-bit down-counter loaded with SETTLE−1. Return to IDLE when it reaches 0.
- Input changes during LOAD..SETTLE are not captured. IDLE re-compares on its first cycle, so the latest value wins and intermediate values are dropped.
- Interlock:
  - `tx_grant` is set only in IDLE when `sent_valid`, `sent_word[15]`=1, `ptt_req`=1 and the live word = `sent_word`.
  - `tx_grant` is cleared the cycle after `ptt_req` falls, or the cycle after any LPF/HPF change is seen in IDLE. This is always before LOAD completes, so RF drops before any relay moves.
- Reset mid-transfer: the FSM goes to IDLE and all outputs take their reset values. The partial shift is abandoned and the full word is re-sent afterwards.

## Timing
- Reset values: `tx_grant`=0, `SPI_data`=0, `SPI_clock`=0, `Tx_load_strobe`=0, `busy`=0, state=IDLE.
- Input change to LOAD: 1 cycle. All outputs are registered, so they lag their state by one cycle.
- Full update length is 1 + 32·DIV + DIV + SETTLE cycles; with the defaults, 1 + 128 + 4 + 2048 = 2181 cycles.
- `SPI_data` is stable for DIV cycles before and DIV cycles during `SPI_clock` high.
- `busy` rises the cycle after LOAD is entered and falls the cycle after SETTLE exits.
- `ptt_req` rising with no filter change:
  - The word differs (bit 15), so a full update runs.
  - `tx_grant` rises 1 cycle after returning to IDLE.
  - With the defaults, that is 2183 cycles after `ptt_req` rises.

## Configuration
- `ALEX_TX_INTERLOCK_EN` defined: `tx_grant` follows the interlock rules in Operation.
- `ALEX_TX_INTERLOCK_EN` undefined: `tx_grant` is `ptt_req` registered once (1-cycle delay) and is independent of FSM state. Relay word sequencing is unchanged.

## Test plan
- Reset release with `LPF`=7'b0001000, `HPF`=6'b000001, `ptt_req`=0 → one transfer of 16'h0804, with SPI_data bits sampled on SPI_clock rising edges. `Tx_load_strobe` is high for 4 cycles; `busy` is low 2181 cycles after LOAD.
- Steady inputs for 10000 cycles after the first update → no further SPI_clock edges, `busy`=0.
- In IDLE, `ptt_req` 0→1 → word 16'h8804 is sent; `tx_grant`=1 exactly 2183 cycles after the `ptt_req` edge. `ptt_req` 1→0 → `tx_grant`=0 on the next cycle, before the first SPI_clock rise.
- `LPF` changes 7'b0000001→7'b1000000→7'b0100000 during SHIFT → the current word completes, then exactly one more transfer carries `LPF`=7'b0100000.
- `reset` asserted at bit 7 of SHIFT → all outputs are 0 the next cycle. After release the full word is re-sent from bit 15.
- With `ALEX_TX_INTERLOCK_EN` undefined, `ptt_req` rises during SETTLE → `tx_grant`=1 one cycle later.

Source files
------------

// File: rtl/alex_relay_sequencer.sv
// -----------------------------------------------------------------------------
// alex_relay_sequencer
//
// Purpose:
//   Keeps the Alex filter-board relays in step with the LPF/HPF band decoders
//   and the PTT request. Whenever the 16-bit relay word changes, it is shifted
//   out MSB first on SPI_data/SPI_clock. Tx_load_strobe then latches it into
//   the Alex output registers, and the block waits a relay settle time before
//   it looks at the inputs again.
//
// Relay word:
//   [15] TX relay (ptt_req), [14:8] LPF, [7:2] HPF, [1:0] 2'b00
//
// Ports:
//   clock           in   system clock; all logic is on its rising edge
//   reset           in   synchronous, active-high reset
//   LPF[6:0]        in   one-hot LPF code
//   HPF[5:0]        in   one-hot HPF code
//   ptt_req         in   transmit request
//   tx_grant        out  transmitter may radiate (registered)
//   SPI_data        out  serial relay data, MSB first (registered)
//   SPI_clock       out  serial clock to the Alex shift registers (registered)
//   Tx_load_strobe  out  latch pulse to the Alex output registers (registered)
//   busy            out  high whenever the FSM is not IDLE (registered)
//   dbg_state_o     out  current FSM state encoding, for debug and checkers
//
// Parameters:
//   DIV     clock cycles per SPI_clock half-period (1..255)
//   SETTLE  relay settle time in clock cycles after the strobe (1..65535)
//
// Configuration macro:
//   ALEX_TX_INTERLOCK_EN
//     defined   : tx_grant is only raised in IDLE once the TX word is on the
//                 relays and nothing is pending. It drops as soon as ptt_req
//                 falls or a filter change is seen.
//     undefined : tx_grant is ptt_req delayed by one clock, regardless of
//                 the FSM state.
//
// Handshake and timing:
//   There is no valid/ready pair. The live word is compared with the last
//   word sent whenever the FSM is IDLE. A difference starts an update on the
//   next clock. Inputs are ignored from LOAD through SETTLE. The first IDLE
//   cycle after SETTLE compares again, so the most recent value wins and
//   values that come and go in between are never sent. Every output is a
//   register fed from the current state, so each output lags its state by
//   exactly one clock.
// -----------------------------------------------------------------------------
module alex_relay_sequencer #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned SETTLE = 2048
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] LPF,
  input  logic [5:0] HPF,
  input  logic       ptt_req,
  output logic       tx_grant,
  output logic       SPI_data,
  output logic       SPI_clock,
  output logic       Tx_load_strobe,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_STROBE = 3'd3,
    S_SETTLE = 3'd4
  } state_e;

  // Terminal values for the half-period and settle counters.
  localparam logic [7:0]  DIV_LAST    = 8'(DIV - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  state_e      state_q, state_d;

  logic [15:0] live_word;
  logic        word_changed;

  logic [15:0] shift_q, shift_d;
  logic [15:0] sent_word_q, sent_word_d;
  logic        sent_valid_q, sent_valid_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        phase_q, phase_d;        // 1 while in the SPI_clock-high half
  logic [15:0] settle_cnt_q, settle_cnt_d;

  // Next values of the registered outputs.
  logic        spi_data_d;
  logic        spi_clock_d;
  logic        strobe_d;
  logic        busy_d;
  logic        tx_grant_d;

  assign live_word    = {ptt_req, LPF, HPF, 2'b00};
  // After reset nothing is known about the relays, so the first word is
  // always treated as a change.
  assign word_changed = !sent_valid_q || (live_word != sent_word_q);

  assign dbg_state_o  = state_q;

  // ---------------------------------------------------------------------------
  // Next-state, datapath and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    sent_word_d  = sent_word_q;
    sent_valid_d = sent_valid_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    phase_d      = phase_q;
    settle_cnt_d = settle_cnt_q;

    spi_data_d   = 1'b0;
    spi_clock_d  = 1'b0;
    strobe_d     = 1'b0;
    busy_d       = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (word_changed) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // Capture the word as it is now. A change that lands between the
        // IDLE compare and this cycle is sent, not lost.
        shift_d      = live_word;
        sent_word_d  = live_word;
        sent_valid_d = 1'b1;
        bit_cnt_d    = 4'd0;
        div_cnt_d    = 8'd0;
        phase_d      = 1'b0;
        state_d      = S_SHIFT;
      end

      S_SHIFT: begin
        spi_data_d  = shift_q[15];
        spi_clock_d = phase_q;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = 8'd0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // End of the high half is the SPI falling edge. The next bit
            // appears together with the clock going low, so it is stable
            // for a whole low half and a whole high half.
            phase_d   = 1'b0;
            shift_d   = {shift_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              state_d = S_STROBE;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      S_STROBE: begin
        strobe_d = 1'b1;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d    = 8'd0;
          settle_cnt_d = SETTLE_LAST;
          state_d      = S_SETTLE;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      S_SETTLE: begin
        if (settle_cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef ALEX_TX_INTERLOCK_EN
    // Grant only when the relays already hold the TX word and no update is
    // pending. Any filter change or a falling ptt_req clears it on the next
    // clock, which comes before LOAD has finished, so RF is off before any
    // relay moves.
    tx_grant_d = (state_q == S_IDLE) && sent_valid_q && sent_word_q[15] &&
                 ptt_req && !word_changed;
`else
    tx_grant_d = ptt_req;
`endif
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      shift_q        <= 16'd0;
      sent_word_q    <= 16'd0;
      sent_valid_q   <= 1'b0;
      bit_cnt_q      <= 4'd0;
      div_cnt_q      <= 8'd0;
      phase_q        <= 1'b0;
      settle_cnt_q   <= 16'd0;
      tx_grant       <= 1'b0;
      SPI_data       <= 1'b0;
      SPI_clock      <= 1'b0;
      Tx_load_strobe <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      sent_word_q    <= sent_word_d;
      sent_valid_q   <= sent_valid_d;
      bit_cnt_q      <= bit_cnt_d;
      div_cnt_q      <= div_cnt_d;
      phase_q        <= phase_d;
      settle_cnt_q   <= settle_cnt_d;
      tx_grant       <= tx_grant_d;
      SPI_data       <= spi_data_d;
      SPI_clock      <= spi_clock_d;
      Tx_load_strobe <= strobe_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_alex_relay_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alex_relay_sequencer
//
// Bench for alex_relay_sequencer at its default parameters. The drivers push
// every relay word that should reach the board into exp_q. A separate monitor
// rebuilds each word from SPI_data on SPI_clock rising edges and pops one
// entry from exp_q when the load strobe appears. The monitor also checks the
// SPI half-period lengths, data stability, strobe width, busy length and
// tx_grant behaviour.
// -----------------------------------------------------------------------------
module tb_alex_relay_sequencer;

  localparam int DIV    = 4;
  localparam int SETTLE = 2048;
  localparam int BUSY_LEN = 1 + 32 * DIV + DIV + SETTLE;   // 2181

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] LPF = 7'b0001000;
  logic [5:0] HPF = 6'b000001;
  logic       ptt_req = 1'b0;
  logic       tx_grant;
  logic       SPI_data;
  logic       SPI_clock;
  logic       Tx_load_strobe;
  logic       busy;
  logic [2:0] dbg_state_o;

  always #5 clock = ~clock;

  alex_relay_sequencer #(.DIV(DIV), .SETTLE(SETTLE)) dut (
    .clock          (clock),
    .reset          (reset),
    .LPF            (LPF),
    .HPF            (HPF),
    .ptt_req        (ptt_req),
    .tx_grant       (tx_grant),
    .SPI_data       (SPI_data),
    .SPI_clock      (SPI_clock),
    .Tx_load_strobe (Tx_load_strobe),
    .busy           (busy),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: the board should receive the live word whenever it
  // differs from the last word delivered. Values that come and go while an
  // update is in flight are never sent.
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  logic [15:0] m_last  = 16'd0;
  logic        m_valid = 1'b0;
  int          n_pushed = 0;

  function automatic logic [15:0] relay_word(logic p, logic [6:0] l, logic [5:0] h);
    return {p, l, h, 2'b00};
  endfunction

  function automatic void note_word();
    logic [15:0] w;
    w = relay_word(ptt_req, LPF, HPF);
    if (!m_valid || w != m_last) begin
      exp_q.push_back(w);
      n_pushed++;
      m_last  = w;
      m_valid = 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard (samples on the falling clock edge)
  // ---------------------------------------------------------------------------
  int          rise_cnt = 0;
  int          xfer_cnt = 0;
  int          mon_bits = 0;
  int          high_len = 0;
  int          low_len  = 0;
  int          strobe_len = 0;
  int          busy_len = 0;
  logic [15:0] got_word = 16'd0;
  logic        timing_bad = 1'b0;
  logic        rise_data = 1'b0;
  logic        low_data  = 1'b0;
  logic        prev_clk = 1'b0, prev_strobe = 1'b0, prev_busy = 1'b0;
  logic        prev_rst = 1'b1, prev_ptt = 1'b0;
  logic        last_exp_g = 1'bx;
  logic        last_must0 = 1'b0;

  always @(negedge clock) begin
    logic [15:0] exp_w;
    logic        exp_g;
    logic        must0;
    if (reset) begin
      // Anything half-shifted is abandoned by the DUT, so drop it here too.
      mon_bits    = 0;
      got_word    = 16'd0;
      timing_bad  = 1'b0;
      high_len    = 0;
      low_len     = 0;
      strobe_len  = 0;
      busy_len    = 0;
      prev_clk    = 1'b0;
      prev_strobe = 1'b0;
      prev_busy   = 1'b0;
    end else begin
      if (SPI_clock && !prev_clk) begin
        rise_cnt++;
        if (mon_bits > 0 && (low_len != DIV || SPI_data != low_data)) timing_bad = 1'b1;
        got_word  = {got_word[14:0], SPI_data};
        mon_bits++;
        rise_data = SPI_data;
        high_len  = 1;
      end else if (SPI_clock) begin
        high_len++;
        if (SPI_data != rise_data) timing_bad = 1'b1;
      end else if (prev_clk) begin
        if (high_len != DIV) timing_bad = 1'b1;
        low_len  = 1;
        low_data = SPI_data;
      end else begin
        low_len++;
        if (mon_bits > 0 && SPI_data != low_data) timing_bad = 1'b1;
      end

      if (Tx_load_strobe) strobe_len++;
      if (Tx_load_strobe && !prev_strobe) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 32'(got_word), 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          check("xfer_word", 32'(got_word), 32'(exp_w));
        end
        check("xfer_bits", 32'(mon_bits), 32'd16);
        check("spi_timing_err", 32'(timing_bad), 32'd0);
        check("data_low_at_strobe", {SPI_clock, SPI_data}, 32'd0);
        mon_bits   = 0;
        timing_bad = 1'b0;
      end
      if (!Tx_load_strobe && prev_strobe) begin
        check("strobe_len", 32'(strobe_len), 32'(DIV));
        strobe_len = 0;
      end

      if (busy) busy_len++;
      if (!busy && prev_busy) begin
        check("busy_len", 32'(busy_len), 32'(BUSY_LEN));
        busy_len = 0;
      end

      prev_clk    = SPI_clock;
      prev_strobe = Tx_load_strobe;
      prev_busy   = busy;
    end

`ifdef ALEX_TX_INTERLOCK_EN
    // RF must be off the cycle after a reset or after ptt_req goes low.
    must0 = prev_rst || !prev_ptt;
    if (must0 && !last_must0) check("grant_drop", 32'(tx_grant), 32'd0);
    last_must0 = must0;
`else
    // tx_grant is ptt_req one clock later (zero after a reset cycle).
    exp_g = prev_rst ? 1'b0 : prev_ptt;
    if (exp_g !== last_exp_g) check("grant_follow", 32'(tx_grant), 32'(exp_g));
    last_exp_g = exp_g;
`endif
    prev_rst = reset;
    prev_ptt = ptt_req;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [6:0] l, input logic [5:0] h, input logic p);
    @(posedge clock);
    #1;
    LPF     = l;
    HPF     = h;
    ptt_req = p;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Lets any update and the one that may follow it run to completion.
  task automatic run_quiet();
    for (int r = 0; r < 3; r++) begin
      repeat (4) @(negedge clock);
      wait_idle(6000);
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic wait_bits(input int nbits, input int budget);
    int n = 0;
    while (mon_bits < nbits && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("wait_bits", 32'(mon_bits >= nbits), 32'd1);
  endtask

  task automatic wait_strobe(input int budget);
    int start = xfer_cnt;
    int n = 0;
    while (xfer_cnt == start && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("wait_strobe", 32'(xfer_cnt != start), 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {26'd0, tx_grant, SPI_data, SPI_clock, Tx_load_strobe, busy, 1'b0}, 32'd0);
    check({name, "_state"}, 32'(dbg_state_o), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          saved;
    int          nmid;
    logic [6:0]  rl;
    logic [5:0]  rh;
    logic        rp;

    // Reset state, then the first word after reset is always sent.
    repeat (3) @(negedge clock);
    check_all_zero("reset_outputs");
    note_word();                                   // 16'h0804
    check("first_word", 32'(exp_q[0]), 32'h0804);
    @(posedge clock);
    #1 reset = 1'b0;
    run_quiet();

    // Steady inputs: no more traffic on the serial lines.
    saved = rise_cnt;
    repeat (10000) @(negedge clock);
    check("steady_rises", 32'(rise_cnt - saved), 32'd0);
    check("steady_busy", 32'(busy), 32'd0);

    // ptt_req rising sends the TX word.
    drive(7'b0001000, 6'b000001, 1'b1);
    note_word();                                   // 16'h8804
`ifdef ALEX_TX_INTERLOCK_EN
    repeat (2183) @(negedge clock);
    check("grant_before_2183", 32'(tx_grant), 32'd0);
    @(negedge clock);
    check("grant_at_2183", 32'(tx_grant), 32'd1);
`else
    repeat (2) @(negedge clock);
    check("grant_next_cycle", 32'(tx_grant), 32'd1);
`endif
    run_quiet();

    // ptt_req falling drops RF before the relays start moving.
    saved = rise_cnt;
    drive(7'b0001000, 6'b000001, 1'b0);
    note_word();                                   // 16'h0804
    repeat (2) @(negedge clock);
    check("grant_drop_fast", 32'(tx_grant), 32'd0);
    check("no_rise_before_drop", 32'(rise_cnt - saved), 32'd0);
    run_quiet();

    // LPF changes during SHIFT: only the final value follows.
    drive(7'b0000001, 6'b000001, 1'b0);
    note_word();
    wait_bits(3, 200);
    drive(7'b1000000, 6'b000001, 1'b0);
    repeat (50) @(negedge clock);
    drive(7'b0100000, 6'b000001, 1'b0);
    note_word();
    run_quiet();

    // Reset in the middle of the shift: outputs clear, then the whole word
    // is sent again. It was never strobed, so it stays pending in exp_q.
    drive(7'b0100000, 6'b000100, 1'b0);
    note_word();
    wait_bits(9, 300);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    check_all_zero("midshift_reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    run_quiet();

    // ptt_req rising while the relays settle.
    drive(7'b0000010, 6'b000100, 1'b0);
    note_word();
    wait_strobe(3000);
    repeat (100) @(negedge clock);
    check("in_settle", 32'(busy), 32'd1);
    drive(7'b0000010, 6'b000100, 1'b1);
    note_word();
    repeat (2) @(negedge clock);
`ifdef ALEX_TX_INTERLOCK_EN
    check("grant_held_in_settle", 32'(tx_grant), 32'd0);
`else
    check("grant_in_settle", 32'(tx_grant), 32'd1);
`endif
    run_quiet();

    // Random updates, some with changes piled on while busy.
    for (int it = 0; it < 6; it++) begin
      rl = 7'(7'd1 << $urandom_range(0, 6));
      rh = 6'(6'd1 << $urandom_range(0, 5));
      rp = 1'($urandom_range(0, 1));
      if (m_valid && relay_word(rp, rl, rh) == m_last) rp = ~rp;
      drive(rl, rh, rp);
      note_word();
      nmid = $urandom_range(0, 2);
      for (int j = 0; j < nmid; j++) begin
        repeat ($urandom_range(3, 900)) @(negedge clock);
        drive(7'(7'd1 << $urandom_range(0, 6)), 6'(6'd1 << $urandom_range(0, 5)),
              1'($urandom_range(0, 1)));
      end
      if (nmid > 0) note_word();
      run_quiet();
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("xfer_count", 32'(xfer_cnt), 32'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
